// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg
// Shared types and constants for the machine-mode trap sequencer:
//   exc_cause_e  - exception cause codes (EXC_CAUSE_W bits wide)
//   state_e      - sequencer FSM states
//   CSR_*        - CSR addresses written by the sequencer
//   MTI_CODE     - machine-timer interrupt cause code
package trap_sequencer_pkg;

    localparam int EXC_CAUSE_W = 31;

    typedef enum logic [EXC_CAUSE_W-1:0] {
        EXC_INSN_MISALIGN  = 31'd0,
        EXC_INSN_FAULT     = 31'd1,
        EXC_ILLEGAL_INSN   = 31'd2,
        EXC_BREAKPOINT     = 31'd3,
        EXC_LOAD_MISALIGN  = 31'd4,
        EXC_LOAD_FAULT     = 31'd5,
        EXC_STORE_MISALIGN = 31'd6,
        EXC_STORE_FAULT    = 31'd7,
        EXC_ECALL_U        = 31'd8,
        EXC_ECALL_S        = 31'd9,
        EXC_ECALL_M        = 31'd11,
        EXC_INSN_PAGE      = 31'd12,
        EXC_LOAD_PAGE      = 31'd13,
        EXC_STORE_PAGE     = 31'd15
    } exc_cause_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_EPC,
        ST_WR_CAUSE,
        ST_WR_TVAL,
        ST_REDIRECT
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [EXC_CAUSE_W-1:0] MTI_CODE = 31'd7;

endpackage

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if
// Pipeline <-> trap sequencer bundle.
//   master : pipeline side (drives exception/MRET requests and CSR values)
//   slave  : sequencer side (drives exc_ready, CSR write port, redirect,
//            stall and the mstatus mie/mpie bits)
// Optional: TRAP_SEQUENCER_IRQ_EN adds mtip, mtie and irq_epc.
interface trap_sequencer_if #(
    parameter int XLEN = 32
);
    import trap_sequencer_pkg::*;

    logic             exc_valid;
    exc_cause_e       exc_cause;
    logic [XLEN-1:0]  exc_epc;
    logic [XLEN-1:0]  exc_tval;
    logic             exc_ready;
    logic             mret_valid;
    logic [XLEN-1:0]  mtvec;
    logic [XLEN-1:0]  mepc;
    logic             csr_we;
    logic [11:0]      csr_waddr;
    logic [XLEN-1:0]  csr_wdata;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             stall;
    logic             mie;
    logic             mpie;
`ifdef TRAP_SEQUENCER_IRQ_EN
    logic             mtip;
    logic             mtie;
    logic [XLEN-1:0]  irq_epc;
`endif

    modport master (
`ifdef TRAP_SEQUENCER_IRQ_EN
        output mtip, mtie, irq_epc,
`endif
        output exc_valid, exc_cause, exc_epc, exc_tval, mret_valid, mtvec, mepc,
        input  exc_ready, csr_we, csr_waddr, csr_wdata,
        input  redirect_valid, redirect_pc, stall, mie, mpie
    );

    modport slave (
`ifdef TRAP_SEQUENCER_IRQ_EN
        input  mtip, mtie, irq_epc,
`endif
        input  exc_valid, exc_cause, exc_epc, exc_tval, mret_valid, mtvec, mepc,
        output exc_ready, csr_we, csr_waddr, csr_wdata,
        output redirect_valid, redirect_pc, stall, mie, mpie
    );

endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer
// Machine-mode trap entry/exit sequencer. An accepted trap writes
// mepc, mcause and mtval on three consecutive cycles through a single CSR
// write port, then redirects fetch to mtvec. MRET in IDLE redirects to
// mepc combinationally in the same cycle. mstatus.mie/mpie live here.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high
//   bus    - trap_sequencer_if.slave (requests in; CSR write, redirect,
//            stall, mie/mpie out)
// Optional: define TRAP_SEQUENCER_IRQ_EN for the machine-timer interrupt
// (mtip/mtie/irq_epc inputs, interrupt cause bit, vectored mtvec).
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MCAUSE_W = EXC_CAUSE_W
) (
    input logic           clk,
    input logic           reset,
    trap_sequencer_if.slave bus
);

    state_e               state_q, state_d;
    logic [MCAUSE_W-1:0]  cause_q;
    logic [XLEN-1:0]      epc_q, tval_q;
    logic                 irq_q;
    logic                 mie_q, mpie_q;

    logic                 idle, take_exc, take_irq, take_trap, take_mret;
    logic [XLEN-1:0]      vec_base;

    // Arbitration in IDLE: exception > timer interrupt > MRET.
    always_comb begin
        idle      = (state_q == ST_IDLE);
        take_exc  = idle && bus.exc_valid;
`ifdef TRAP_SEQUENCER_IRQ_EN
        take_irq  = idle && !bus.exc_valid && bus.mtip && bus.mtie && mie_q;
`else
        take_irq  = 1'b0;
`endif
        take_trap = take_exc || take_irq;
        take_mret = idle && bus.mret_valid && !take_trap;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (take_trap) state_d = ST_WR_EPC;
            ST_WR_EPC:   state_d = ST_WR_CAUSE;
            ST_WR_CAUSE: state_d = ST_WR_TVAL;
            ST_WR_TVAL:  state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Trap context latch and mstatus interrupt-enable stack
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            irq_q   <= 1'b0;
            mie_q   <= 1'b0;
            mpie_q  <= 1'b0;
        end else if (take_trap) begin
            irq_q  <= take_irq;
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
`ifdef TRAP_SEQUENCER_IRQ_EN
            if (take_irq) begin
                cause_q <= MCAUSE_W'(MTI_CODE);
                epc_q   <= bus.irq_epc;
                tval_q  <= '0;
            end else
`endif
            begin
                cause_q <= MCAUSE_W'(bus.exc_cause);
                epc_q   <= bus.exc_epc;
                tval_q  <= bus.exc_tval;
            end
        end else if (take_mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end
    end

    assign vec_base = {bus.mtvec[XLEN-1:2], 2'b00};
    assign bus.mie  = mie_q;
    assign bus.mpie = mpie_q;

    // Output logic
    always_comb begin
        bus.exc_ready      = idle;
        bus.stall          = !idle;
        bus.csr_we         = 1'b0;
        bus.csr_waddr      = '0;
        bus.csr_wdata      = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        case (state_q)
            ST_IDLE: begin
                if (take_mret) begin
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = bus.mepc;
                end
            end
            ST_WR_EPC: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_MEPC;
                bus.csr_wdata = epc_q;
            end
            ST_WR_CAUSE: begin
                bus.csr_we              = 1'b1;
                bus.csr_waddr           = CSR_MCAUSE;
                bus.csr_wdata           = XLEN'(cause_q);
                bus.csr_wdata[XLEN-1]   = irq_q;
            end
            ST_WR_TVAL: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_MTVAL;
                bus.csr_wdata = tval_q;
            end
            ST_REDIRECT: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = vec_base;
`ifdef TRAP_SEQUENCER_IRQ_EN
                // Vectored mode applies to interrupts only.
                if (irq_q && bus.mtvec[1:0] == 2'b01)
                    bus.redirect_pc = vec_base + (XLEN'(cause_q) << 2);
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer
// Self-checking bench for trap_sequencer. A per-cycle expected transcript is
// built from the trap/MRET rules (write mepc, mcause, mtval, redirect; MRET
// redirects same-cycle) and an abstract mie/mpie model, then compared
// against the observed outputs every cycle. Honors TRAP_SEQUENCER_IRQ_EN.
module tb_trap_sequencer;
    import trap_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trap_sequencer_if #(.XLEN(32)) bus();

    trap_sequencer #(.XLEN(32), .MCAUSE_W(EXC_CAUSE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic m_mie, m_mpie;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        rv;
        logic [31:0] rpc;
        logic        stall;
        logic        rdy;
        logic        mie;
        logic        mpie;
    } obs_t;

    int unsigned causes [8] = '{0, 1, 2, 3, 5, 7, 8, 11};

    // Observed outputs; address/data and redirect pc only matter when the
    // expected strobe is set.
    function automatic obs_t observe(input obs_t e);
        obs_t o;
        o.we    = bus.csr_we;
        o.addr  = e.we ? bus.csr_waddr : 12'h0;
        o.data  = e.we ? bus.csr_wdata : 32'h0;
        o.rv    = bus.redirect_valid;
        o.rpc   = e.rv ? bus.redirect_pc : 32'h0;
        o.stall = bus.stall;
        o.rdy   = bus.exc_ready;
        o.mie   = bus.mie;
        o.mpie  = bus.mpie;
        return o;
    endfunction

    function automatic obs_t idle_exp();
        obs_t o = '0;
        o.rdy  = 1'b1;
        o.mie  = m_mie;
        o.mpie = m_mpie;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.exc_valid  = 1'b0;
        bus.mret_valid = 1'b0;
`ifdef TRAP_SEQUENCER_IRQ_EN
        bus.mtip = 1'b0;
        bus.mtie = 1'b0;
`endif
    endtask

    task automatic check_idle(input string nm);
        obs_t e, got;
        drive_idle();
        bus.mtvec = $urandom;
        bus.mepc  = $urandom;
        #1;
        e = idle_exp();
        got = observe(e);
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, e);
        end
        tick();
    endtask

    task automatic run_mret(input string nm, input logic [31:0] mepc_v);
        obs_t e, got;
        drive_idle();
        bus.mret_valid = 1'b1;
        bus.mepc       = mepc_v;
        bus.mtvec      = $urandom;
        #1;
        e = idle_exp();
        e.rv  = 1'b1;
        e.rpc = mepc_v;
        got = observe(e);
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, e);
        end
        tick();
        m_mie  = m_mpie;
        m_mpie = 1'b1;
        bus.mret_valid = 1'b0;
    endtask

    // One trap: acceptance cycle (k=0) then four sequencer cycles.
    // nx_* optionally presents a second request from WR_CAUSE onward;
    // abort_at asserts reset during cycle k.
    task automatic run_trap(input string nm, input logic [30:0] cause,
                            input logic [31:0] epc, input logic [31:0] tval,
                            input logic irq, input logic [31:0] tvec,
                            input logic with_mret, input logic nx_valid,
                            input logic [30:0] nx_cause, input logic [31:0] nx_epc,
                            input logic [31:0] nx_tval, input int abort_at);
        obs_t e, got;
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        bus.mtvec      = tvec;
        bus.mepc       = $urandom;
        bus.mret_valid = with_mret;
        if (irq) begin
            bus.exc_valid = 1'b0;
            bus.exc_epc   = $urandom;
            bus.exc_tval  = $urandom;
`ifdef TRAP_SEQUENCER_IRQ_EN
            bus.mtip    = 1'b1;
            bus.mtie    = 1'b1;
            bus.irq_epc = epc;
`endif
        end else begin
            bus.exc_valid = 1'b1;
            bus.exc_cause = exc_cause_e'(cause);
            bus.exc_epc   = epc;
            bus.exc_tval  = tval;
`ifdef TRAP_SEQUENCER_IRQ_EN
            bus.mtip    = 1'($urandom);
            bus.mtie    = 1'($urandom);
            bus.irq_epc = $urandom;
`endif
        end
        #1;
        e = idle_exp();
        got = observe(e);
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s c0: got %h expected %h", nm, got, e);
        end
        tick();
        m_mpie = m_mie;
        m_mie  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.exc_valid = nx_valid && (k >= 2);
            if (nx_valid) begin
                bus.exc_cause = exc_cause_e'(nx_cause);
                bus.exc_epc   = nx_epc;
                bus.exc_tval  = nx_tval;
            end else begin
                bus.exc_epc  = $urandom;
                bus.exc_tval = $urandom;
            end
            bus.mret_valid = 1'($urandom);
            bus.mepc       = $urandom;
`ifdef TRAP_SEQUENCER_IRQ_EN
            bus.mtip    = 1'($urandom);
            bus.mtie    = 1'($urandom);
            bus.irq_epc = $urandom;
`endif
            #1;
            e = '0;
            e.stall = 1'b1;
            e.mie   = m_mie;
            e.mpie  = m_mpie;
            case (k)
                1: begin e.we = 1'b1; e.addr = 12'h341; e.data = epc; end
                2: begin e.we = 1'b1; e.addr = 12'h342;
                         e.data = irq ? 32'h8000_0007 : {1'b0, cause}; end
                3: begin e.we = 1'b1; e.addr = 12'h343; e.data = irq ? 32'h0 : tval; end
                default: begin e.rv = 1'b1;
                         e.rpc = (irq && tvec[1:0] == 2'b01) ? base + 32'd28 : base; end
            endcase
            got = observe(e);
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s c%0d: got %h expected %h", nm, k, got, e);
            end
            if (abort_at == k) reset = 1'b1;
            tick();
            if (abort_at == k) begin
                reset  = 1'b0;
                m_mie  = 1'b0;
                m_mpie = 1'b0;
                break;
            end
        end
        bus.mret_valid = 1'b0;
        if (!nx_valid) bus.exc_valid = 1'b0;
`ifdef TRAP_SEQUENCER_IRQ_EN
        bus.mtip = 1'b0;
        bus.mtie = 1'b0;
`endif
    endtask

    task automatic test_reset();
        obs_t e, got;
        reset = 1'b1;
        drive_idle();
        bus.exc_cause = EXC_INSN_MISALIGN;
        bus.exc_epc   = '0;
        bus.exc_tval  = '0;
        bus.mtvec     = '0;
        bus.mepc      = '0;
`ifdef TRAP_SEQUENCER_IRQ_EN
        bus.irq_epc = '0;
`endif
        tick();
        tick();
        reset  = 1'b0;
        m_mie  = 1'b0;
        m_mpie = 1'b0;
        #1;
        e = idle_exp();
        got = observe(e);
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset: got %h expected %h", got, e);
        end
        tick();
    endtask

    task automatic test_mret();
        run_mret("mret_first", 32'h104);
        run_mret("mret_second", 32'h104);
        check_idle("mret_after");
    endtask

    task automatic test_illegal();
        run_trap("illegal", 31'd2, 32'h100, 32'hDEAD, 1'b0, 32'h800, 1'b0,
                 1'b0, 31'd0, 32'h0, 32'h0, 0);
        check_idle("illegal_after");
    endtask

    task automatic test_exc_and_mret();
        run_mret("mret_restore", 32'h200);
        run_trap("exc_mret", 31'd11, 32'h300, 32'h0, 1'b0, 32'h1000, 1'b1,
                 1'b0, 31'd0, 32'h0, 32'h0, 0);
        check_idle("exc_mret_after");
    endtask

    task automatic test_back_to_back();
        run_trap("b2b_first", 31'd5, 32'h400, 32'h1111, 1'b0, 32'h2001, 1'b0,
                 1'b1, 31'd7, 32'h500, 32'h2222, 0);
        run_trap("b2b_second", 31'd7, 32'h500, 32'h2222, 1'b0, 32'h2001, 1'b0,
                 1'b0, 31'd0, 32'h0, 32'h0, 0);
        check_idle("b2b_after");
    endtask

    task automatic test_reset_abort();
        run_mret("abort_restore", 32'h600);
        run_trap("abort", 31'd3, 32'h700, 32'h3333, 1'b0, 32'h900, 1'b0,
                 1'b0, 31'd0, 32'h0, 32'h0, 2);
        check_idle("abort_idle");
        check_idle("abort_idle2");
    endtask

`ifdef TRAP_SEQUENCER_IRQ_EN
    task automatic test_irq();
        obs_t e, got;
        drive_idle();
        bus.mtip = 1'b1;
        bus.mtie = 1'b1;
        #1;
        e = idle_exp();
        got = observe(e);
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL irq_masked: got %h expected %h", got, e);
        end
        tick();
        run_mret("irq_restore1", 32'h10);
        run_mret("irq_restore2", 32'h14);
        run_trap("irq_vec", 31'd0, 32'hABC0, 32'h0, 1'b1, 32'h801, 1'b1,
                 1'b0, 31'd0, 32'h0, 32'h0, 0);
        check_idle("irq_after");
    endtask
`endif

    task automatic test_random();
        int op;
        for (int i = 0; i < 60; i++) begin
`ifdef TRAP_SEQUENCER_IRQ_EN
            op = $urandom_range(4, 0);
`else
            op = $urandom_range(3, 0);
`endif
            case (op)
                0, 1: run_trap("rnd_trap", 31'(causes[$urandom_range(7, 0)]),
                               $urandom, $urandom, 1'b0, $urandom, 1'($urandom),
                               1'b0, 31'd0, 32'h0, 32'h0, 0);
                2: run_mret("rnd_mret", $urandom);
                3: check_idle("rnd_idle");
                default: begin
                    if (m_mie)
                        run_trap("rnd_irq", 31'd0, $urandom, 32'h0, 1'b1, $urandom,
                                 1'($urandom), 1'b0, 31'd0, 32'h0, 32'h0, 0);
                    else
                        run_mret("rnd_mret2", $urandom);
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_mret();
        test_illegal();
        test_exc_and_mret();
        test_back_to_back();
        test_reset_abort();
`ifdef TRAP_SEQUENCER_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
